// File: rtl/ex_div_if.sv
// Execute-stage divider request/response bundle: the EX stage drives through master,
// the divider answers through slave.
interface ex_div_if #(parameter int DW = 32);
    logic          flush_i;
    logic          start_i;
    logic          signed_i;
    logic          rem_i;
    logic [DW-1:0] dividend_i;
    logic [DW-1:0] divisor_i;
    logic [DW-1:0] result_o;
    logic          ready_o;
    logic          stall_req_o;

    modport master (
        output flush_i, start_i, signed_i, rem_i, dividend_i, divisor_i,
        input  result_o, ready_o, stall_req_o
    );

    modport slave (
        input  flush_i, start_i, signed_i, rem_i, dividend_i, divisor_i,
        output result_o, ready_o, stall_req_o
    );
endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU), one operation in flight.
// Latency: DW+1 cycles start-to-ready; DIV_EARLY_OUT_EN gives 1 cycle for div-by-zero/overflow.
// Backpressure: stalls the pipeline via stall_req_o while pending; flush aborts silently.
module ex_div #(
    parameter int DW = 32
) (
    input  logic  clk_i,
    input  logic  n_rst_i,
    ex_div_if.slave dif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int         CW   = $clog2(DW);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] quo;
    logic [DW-1:0] dsr;
    logic [DW:0]   prem;
    logic          neg_q;
    logic          neg_r;
    logic          rem_sel;
    logic          div_zero;

    logic          a_neg;
    logic          b_neg;
    logic [DW-1:0] a_mag;
    logic [DW-1:0] b_mag;
    logic          in_zero;
    logic [DW:0]   prem_sh;
    logic          take;
    logic [DW:0]   prem_nxt;
    logic [DW-1:0] quo_nxt;
    logic [DW-1:0] q_fin;
    logic [DW-1:0] r_fin;
    logic [DW-1:0] fin_res;

    always_comb begin
        a_neg   = dif.signed_i & dif.dividend_i[DW-1];
        b_neg   = dif.signed_i & dif.divisor_i[DW-1];
        a_mag   = a_neg ? (~dif.dividend_i + 1'b1) : dif.dividend_i;
        b_mag   = b_neg ? (~dif.divisor_i + 1'b1) : dif.divisor_i;
        in_zero = (dif.divisor_i == '0);
    end

`ifdef DIV_EARLY_OUT_EN
    logic          in_ovf;
    logic [DW-1:0] early_res;

    // Overflow operands are already the required quotient (dividend) and remainder (0).
    always_comb begin
        in_ovf    = dif.signed_i && (dif.dividend_i == {1'b1, {(DW-1){1'b0}}})
                    && (dif.divisor_i == '1);
        early_res = in_zero ? (dif.rem_i ? dif.dividend_i : '1)
                            : (dif.rem_i ? '0 : dif.dividend_i);
    end
`endif

    // Shift-subtract step; the final step's outputs feed the result register directly.
    always_comb begin
        prem_sh  = {prem[DW-1:0], quo[DW-1]};
        take     = (prem_sh >= {1'b0, dsr});
        prem_nxt = take ? (prem_sh - {1'b0, dsr}) : prem_sh;
        quo_nxt  = {quo[DW-2:0], take};
        q_fin    = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
        r_fin    = neg_r ? (~prem_nxt[DW-1:0] + 1'b1) : prem_nxt[DW-1:0];
        // A zero divisor naturally leaves |dividend| as remainder; only the quotient is forced.
        fin_res  = rem_sel ? r_fin : (div_zero ? '1 : q_fin);
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            quo          <= '0;
            dsr          <= '0;
            prem         <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            rem_sel      <= 1'b0;
            div_zero     <= 1'b0;
            dif.result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dif.start_i && !dif.flush_i) begin
`ifdef DIV_EARLY_OUT_EN
                        if (in_zero || in_ovf) begin
                            dif.result_o <= early_res;
                            state        <= DONE;
                        end else
`endif
                        begin
                            quo      <= a_mag;
                            dsr      <= b_mag;
                            prem     <= '0;
                            cnt      <= '0;
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            rem_sel  <= dif.rem_i;
                            div_zero <= in_zero;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (dif.flush_i) begin
                        state <= IDLE;
                    end else begin
                        prem <= prem_nxt;
                        quo  <= quo_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(DW-1)) begin
                            dif.result_o <= fin_res;
                            state        <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dif.ready_o     = (state == DONE) && !dif.flush_i;
    assign dif.stall_req_o = n_rst_i &&
                             (((state == IDLE) && dif.start_i && !dif.flush_i) || (state == CALC));

endmodule
